vga_sprite_overlay: RTL and testbench

//   Parametrised multi-sprite overlay for the 640x480 VGA path: draws NUM_SPRITES solid rectangles over the

---
 rtl/vga_pkg.sv | 20 ++
 rtl/btn_sync.sv | 39 +++
 rtl/vga_sprite_overlay.sv | 205 ++++++++++++++++++++
 tb/tb_vga_sprite_overlay.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the sprite overlay path.
// Contents: frame geometry defaults, colour width, coordinate widths,
// colour type and sprite position payload.
package vga_pkg;

   localparam int unsigned WIDTH      = 640;
   localparam int unsigned HEIGHT     = 480;
   localparam int unsigned COLOR_BITS = 12;
   localparam int unsigned XW         = $clog2(WIDTH);
   localparam int unsigned YW         = $clog2(HEIGHT);

   typedef logic [COLOR_BITS-1:0] color_t;

   // Top-left corner of a sprite
   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } pos_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw push button, with a registered
// rising-edge pulse derived from the synchronised level.
// Ports:
//   clk, reset   pixel clock, async active-low reset
//   i_btn        raw asynchronous button
//   o_level      synchronised level (2 clk after the input)
//   o_rise       one-clk pulse on a synchronised 0->1 transition
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;

   // Synchroniser chain and edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_btn;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_rise;

endmodule

// File: rtl/vga_sprite_overlay.sv
// Multi-sprite overlay between the palette/timing path and the VGA pins.
// Draws NUM_SPRITES solid rectangles over bgColor; one sprite at a time is
// selected (BTNC) and moved once per frame (BTNU/D/L/R), with a 1-px outline.
// Ports:
//   clk, reset            pixel clock, async active-low reset
//   BTNU/BTND/BTNL/BTNR   raw direction buttons
//   BTNC                  raw select button
//   screenEnd             one-clk pulse between frames
//   active, hSyncIn, vSyncIn, x, y, bgColor   timing/pixel input
//   hSyncOut, vSyncOut, colorOut               1-clk delayed outputs
//   selIndex              selected sprite index
module vga_sprite_overlay #(
   parameter int unsigned WIDTH        = vga_pkg::WIDTH,
   parameter int unsigned HEIGHT       = vga_pkg::HEIGHT,
   parameter int unsigned NUM_SPRITES  = 4,
   parameter int unsigned SPRITE_W     = 75,
   parameter int unsigned SPRITE_H     = 75,
   parameter int unsigned STEP         = 1,
   parameter int unsigned INIT_X       = 40,
   parameter int unsigned INIT_Y       = 200,
   parameter int unsigned INIT_SPACING = 150,
   parameter int unsigned COLOR_BITS   = vga_pkg::COLOR_BITS,
   parameter logic [NUM_SPRITES*COLOR_BITS-1:0] SPRITE_COLORS =
      {12'h00F, 12'h0F0, 12'hF00, 12'h000},
   parameter logic [COLOR_BITS-1:0] HILITE_COLOR = 12'hFFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  BTNU,
   input  logic                  BTND,
   input  logic                  BTNL,
   input  logic                  BTNR,
   input  logic                  BTNC,
   input  logic                  screenEnd,
   input  logic                  active,
   input  logic                  hSyncIn,
   input  logic                  vSyncIn,
   input  logic [9:0]            x,
   input  logic [8:0]            y,
   input  logic [COLOR_BITS-1:0] bgColor,
   output logic                  hSyncOut,
   output logic                  vSyncOut,
   output logic [COLOR_BITS-1:0] colorOut,
   output logic [2:0]            selIndex
);

   import vga_pkg::*;

   localparam int unsigned XMAX = WIDTH - SPRITE_W;
   localparam int unsigned YMAX = HEIGHT - SPRITE_H;
   localparam logic signed [XW:0] XMAX_S = (XW+1)'(XMAX);
   localparam logic signed [YW:0] YMAX_S = (YW+1)'(YMAX);
   localparam logic signed [XW:0] STEP_X = (XW+1)'(STEP);
   localparam logic signed [YW:0] STEP_Y = (YW+1)'(STEP);

   // Reset column of sprite i, kept fully on screen
   function automatic logic [XW-1:0] init_x(input int unsigned i);
      int unsigned v;
      v = INIT_X + i * INIT_SPACING;
      if (v > XMAX) v = XMAX;
      return XW'(v);
   endfunction

   // Button synchronisers: index 0..4 = U, D, L, R, C
   logic [4:0] w_btn_raw;
   logic [4:0] w_lvl;
   logic [4:0] w_rise;
   logic       w_unused;

   assign w_btn_raw = {BTNC, BTNR, BTNL, BTND, BTNU};

   for (genvar g = 0; g < 5; g++) begin : g_btn
      btn_sync u_sync (
         .clk     (clk),
         .reset   (reset),
         .i_btn   (w_btn_raw[g]),
         .o_level (w_lvl[g]),
         .o_rise  (w_rise[g])
      );
   end

   assign w_unused = ^{w_lvl[4], w_rise[3:0]};

   pos_t       r_pos [NUM_SPRITES];
   logic [2:0] r_sel;

   pos_t              w_cur;
   pos_t              w_nxt;
   logic signed [XW:0] w_dx;
   logic signed [YW:0] w_dy;
   logic signed [XW:0] w_xs;
   logic signed [YW:0] w_ys;

   // Position of the currently selected sprite
   always_comb begin
      w_cur = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (r_sel == 3'(i)) w_cur = r_pos[i];
      end
   end

   // Next position: opposing buttons cancel, result saturates at the screen edges
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      if (w_lvl[3] && !w_lvl[2]) w_dx = STEP_X;
      else if (w_lvl[2] && !w_lvl[3]) w_dx = -STEP_X;
      if (w_lvl[1] && !w_lvl[0]) w_dy = STEP_Y;
      else if (w_lvl[0] && !w_lvl[1]) w_dy = -STEP_Y;

      w_xs = $signed({1'b0, w_cur.x}) + w_dx;
      w_ys = $signed({1'b0, w_cur.y}) + w_dy;

      if (w_xs < 0)           w_nxt.x = '0;
      else if (w_xs > XMAX_S) w_nxt.x = XMAX_S[XW-1:0];
      else                    w_nxt.x = w_xs[XW-1:0];

      if (w_ys < 0)           w_nxt.y = '0;
      else if (w_ys > YMAX_S) w_nxt.y = YMAX_S[YW-1:0];
      else                    w_nxt.y = w_ys[YW-1:0];
   end

   // Movement uses the pre-edge selection; a same-cycle select edge applies afterwards
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_pos[i].x <= init_x(i);
            r_pos[i].y <= YW'(INIT_Y);
         end
         r_sel <= '0;
      end else begin
         if (screenEnd) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               if (r_sel == 3'(i)) r_pos[i] <= w_nxt;
            end
         end
         if (w_rise[4]) begin
            r_sel <= (r_sel == 3'(NUM_SPRITES - 1)) ? 3'd0 : r_sel + 3'd1;
         end
      end
   end

   // Per-sprite hit and border tests (inclusive left/top, exclusive right/bottom)
   logic [NUM_SPRITES-1:0] w_hit;
   logic [NUM_SPRITES-1:0] w_edge;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
      logic [XW:0] w_x0;
      logic [YW:0] w_y0;
      logic [XW:0] w_px;
      logic [YW:0] w_py;
      assign w_x0 = {1'b0, r_pos[g].x};
      assign w_y0 = {1'b0, r_pos[g].y};
      assign w_px = {1'b0, x};
      assign w_py = {1'b0, y};
      assign w_hit[g]  = (w_px >= w_x0) && (w_px < w_x0 + (XW+1)'(SPRITE_W)) &&
                         (w_py >= w_y0) && (w_py < w_y0 + (YW+1)'(SPRITE_H));
      assign w_edge[g] = (w_px == w_x0) || (w_px == w_x0 + (XW+1)'(SPRITE_W - 1)) ||
                         (w_py == w_y0) || (w_py == w_y0 + (YW+1)'(SPRITE_H - 1));
   end

   logic                  w_hit_any;
   logic                  w_outline;
   logic [COLOR_BITS-1:0] w_col;

   // Lowest-index hit wins; the selected sprite's outline beats every sprite
   always_comb begin
      w_hit_any = 1'b0;
      w_outline = 1'b0;
      w_col     = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (w_hit[i] && !w_hit_any) begin
            w_hit_any = 1'b1;
            w_col     = SPRITE_COLORS[i*COLOR_BITS +: COLOR_BITS];
         end
         if ((r_sel == 3'(i)) && w_hit[i] && w_edge[i]) w_outline = 1'b1;
      end
   end

   logic [COLOR_BITS-1:0] r_color;
   logic                  r_hs;
   logic                  r_vs;

   // Single output stage keeping colour aligned with the syncs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_color <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
      end else begin
         r_hs <= hSyncIn;
         r_vs <= vSyncIn;
         if (!active)        r_color <= '0;
         else if (w_outline) r_color <= HILITE_COLOR;
         else if (w_hit_any) r_color <= w_col;
         else                r_color <= bgColor;
      end
   end

   assign colorOut = r_color;
   assign hSyncOut = r_hs;
   assign vSyncOut = r_vs;
   assign selIndex = r_sel;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Self-checking bench for vga_sprite_overlay: a behavioural pixel/position
// model is compared against the DUT every cycle, plus literal pixel probes.
module tb_vga_sprite_overlay;
   import vga_pkg::*;

   localparam int NS  = 4;
   localparam int SW  = 75;
   localparam int SH  = 75;
   localparam int STP = 1;
   localparam int XMX = 640 - SW;
   localparam int YMX = 480 - SH;
   localparam color_t BG = 12'hABC;

   logic clk = 1'b0;
   logic reset;
   logic BTNU, BTND, BTNL, BTNR, BTNC;
   logic screenEnd, active, hSyncIn, vSyncIn;
   logic [9:0] x;
   logic [8:0] y;
   color_t bgColor;
   logic hSyncOut, vSyncOut;
   color_t colorOut;
   logic [2:0] selIndex;

   always #20 clk = ~clk;

   vga_sprite_overlay dut (
      .clk(clk), .reset(reset),
      .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
      .screenEnd(screenEnd), .active(active), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
      .x(x), .y(y), .bgColor(bgColor),
      .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .colorOut(colorOut), .selIndex(selIndex)
   );

   // ---------------- behavioural model ----------------
   color_t col_tab [NS] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F};
   int m_sx [NS];
   int m_sy [NS];
   int m_sel;
   logic [4:0] d1, d2, d3, d4;   // button samples 1..4 edges ago, {C,R,L,D,U}
   color_t exp_color;
   logic exp_h, exp_v;
   logic [2:0] exp_sel;
   int dxm, dym;

   // literal probe request (stimulus) and its aligned copy (compare)
   bit pin_req_en, pin_chk_en;
   string pin_req_name, pin_chk_name;
   color_t pin_req_col, pin_chk_col;
   int pin_req_sel, pin_chk_sel;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   function automatic bit in_spr(input int i, input int px, input int py);
      return px >= m_sx[i] && px < m_sx[i] + SW && py >= m_sy[i] && py < m_sy[i] + SH;
   endfunction

   function automatic bit on_border(input int i, input int px, input int py);
      return px == m_sx[i] || px == m_sx[i] + SW - 1 || py == m_sy[i] || py == m_sy[i] + SH - 1;
   endfunction

   function automatic color_t ref_pixel(input logic act, input int px, input int py, input color_t bg);
      int top;
      if (!act) return 12'h000;
      if (in_spr(m_sel, px, py) && on_border(m_sel, px, py)) return 12'hFFF;
      top = -1;
      for (int i = 0; i < NS; i++) if (top < 0 && in_spr(i, px, py)) top = i;
      if (top >= 0) return col_tab[top];
      return bg;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         pin_chk_en   = pin_req_en;
         pin_chk_name = pin_req_name;
         pin_chk_col  = pin_req_col;
         pin_chk_sel  = pin_req_sel;
         if (!reset) begin
            for (int i = 0; i < NS; i++) begin
               m_sx[i] = clampi(40 + 150 * i, XMX);
               m_sy[i] = 200;
            end
            m_sel = 0;
            d1 = '0; d2 = '0; d3 = '0; d4 = '0;
            exp_color = '0; exp_h = 1'b1; exp_v = 1'b1; exp_sel = '0;
         end else begin
            exp_color = ref_pixel(active, int'(x), int'(y), bgColor);
            exp_h = hSyncIn;
            exp_v = vSyncIn;
            if (screenEnd) begin
               dxm = (d2[3] && !d2[2]) ? STP : (d2[2] && !d2[3]) ? -STP : 0;
               dym = (d2[1] && !d2[0]) ? STP : (d2[0] && !d2[1]) ? -STP : 0;
               m_sx[m_sel] = clampi(m_sx[m_sel] + dxm, XMX);
               m_sy[m_sel] = clampi(m_sy[m_sel] + dym, YMX);
            end
            if (d3[4] && !d4[4]) m_sel = (m_sel + 1) % NS;
            exp_sel = 3'(m_sel);
            d4 = d3; d3 = d2; d2 = d1;
            d1 = {BTNC, BTNR, BTNL, BTND, BTNU};
         end
      end
   end

   // ---------------- compare process ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("colorOut", 32'(colorOut), 32'(exp_color));
            chk("hSyncOut", 32'(hSyncOut), 32'(exp_h));
            chk("vSyncOut", 32'(vSyncOut), 32'(exp_v));
            chk("selIndex", 32'(selIndex), 32'(exp_sel));
            if (pin_chk_en) begin
               chk({pin_chk_name, " dut"},   32'(colorOut),  32'(pin_chk_col));
               chk({pin_chk_name, " model"}, 32'(exp_color), 32'(pin_chk_col));
               chk({pin_chk_name, " sel"},   32'(selIndex),  32'(pin_chk_sel));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_rand();
      int px, py, k;
      if ($urandom_range(0, 1) == 0) begin
         k  = $urandom_range(0, NS - 1);
         px = clampi(m_sx[k] - 2 + int'($urandom_range(0, 78)), 639);
         py = clampi(m_sy[k] - 2 + int'($urandom_range(0, 78)), 479);
      end else begin
         px = $urandom_range(0, 639);
         py = $urandom_range(0, 479);
      end
      x       = 10'(px);
      y       = 9'(py);
      active  = ($urandom_range(0, 9) != 0);
      bgColor = 12'($urandom);
      hSyncIn = 1'($urandom);
      vSyncIn = 1'($urandom);
   endtask

   task automatic cyc();
      drive_rand();
      @(negedge clk);
   endtask

   task automatic frame();
      repeat (4) cyc();
      screenEnd = 1'b1;
      cyc();
      screenEnd = 1'b0;
   endtask

   task automatic press();
      BTNC = 1'b1;
      repeat (4) cyc();
      BTNC = 1'b0;
      repeat (4) cyc();
   endtask

   task automatic probe(input string name, input int px, input int py, input logic act,
                        input color_t c, input int s);
      x = 10'(px); y = 9'(py); active = act; bgColor = BG;
      hSyncIn = 1'($urandom); vSyncIn = 1'($urandom);
      pin_req_en = 1'b1; pin_req_name = name; pin_req_col = c; pin_req_sel = s;
      @(negedge clk);
      pin_req_en = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      {BTNU, BTND, BTNL, BTNR, BTNC} = '0;
      screenEnd = 1'b0; active = 1'b0; hSyncIn = 1'b1; vSyncIn = 1'b1;
      x = '0; y = '0; bgColor = '0;
      pin_req_en = 1'b0; pin_req_name = ""; pin_req_col = '0; pin_req_sel = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      probe("reset_black", 190, 200, 1'b1, 12'h000, 0);
      repeat (2) cyc();
      reset = 1'b1;
      repeat (3) cyc();
      probe("spr1_init", 190, 200, 1'b1, 12'hF00, 0);
      probe("spr0_init_outline", 40, 200, 1'b1, 12'hFFF, 0);
      probe("spr1_left_bg", 189, 200, 1'b1, BG, 0);

      // sprite 0 right by three frames
      BTNR = 1'b1;
      repeat (3) frame();
      BTNR = 1'b0;
      repeat (3) cyc();
      probe("r3_outline", 43, 200, 1'b1, 12'hFFF, 0);
      probe("r3_fill", 44, 201, 1'b1, 12'h000, 0);
      probe("r3_left_bg", 42, 200, 1'b1, BG, 0);

      // left clamp, U+D cancel, diagonal
      BTNL = 1'b1;
      repeat (50) frame();
      BTNL = 1'b0;
      repeat (3) cyc();
      probe("clamp_left", 0, 200, 1'b1, 12'hFFF, 0);
      BTNU = 1'b1; BTND = 1'b1;
      repeat (3) frame();
      BTNU = 1'b0; BTND = 1'b0;
      repeat (3) cyc();
      probe("ud_hold_top", 0, 200, 1'b1, 12'hFFF, 0);
      probe("ud_hold_above", 0, 199, 1'b1, BG, 0);
      BTNU = 1'b1; BTNR = 1'b1;
      frame();
      BTNU = 1'b0; BTNR = 1'b0;
      repeat (3) cyc();
      probe("diag_corner", 1, 199, 1'b1, 12'hFFF, 0);
      probe("diag_left_bg", 0, 199, 1'b1, BG, 0);
      probe("diag_right_col", 75, 199, 1'b1, 12'hFFF, 0);
      probe("diag_past_right", 76, 199, 1'b1, BG, 0);

      // selection cycling
      press(); probe("sel1", 600, 10, 1'b1, BG, 1);
      press(); probe("sel2", 600, 10, 1'b1, BG, 2);
      press(); probe("sel3", 600, 10, 1'b1, BG, 3);
      press(); probe("sel0", 600, 10, 1'b1, BG, 0);

      // select edge coincident with screenEnd: old sprite (0) moves down
      BTND = 1'b1;
      repeat (4) cyc();
      BTNC = 1'b1;
      repeat (3) cyc();
      screenEnd = 1'b1;
      cyc();
      screenEnd = 1'b0; BTND = 1'b0; BTNC = 1'b0;
      repeat (4) cyc();
      probe("coinc_moved", 1, 200, 1'b1, 12'h000, 1);
      probe("coinc_above", 1, 199, 1'b1, BG, 1);

      // sprite 1 over sprite 0
      BTNL = 1'b1;
      repeat (150) frame();
      BTNL = 1'b0;
      repeat (3) cyc();
      probe("overlap_low_wins", 50, 220, 1'b1, 12'h000, 1);
      probe("overlap_outline", 40, 220, 1'b1, 12'hFFF, 1);
      probe("spr1_fill", 100, 220, 1'b1, 12'hF00, 1);
      probe("spr1_right_col", 114, 220, 1'b1, 12'hFFF, 1);
      press();
      probe("overlap_unsel", 40, 220, 1'b1, 12'h000, 2);

      // blanking inside a sprite
      probe("blank_spr1", 100, 220, 1'b0, 12'h000, 2);
      probe("blank_spr0", 50, 220, 1'b0, 12'h000, 2);

      // randomized phase
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 15) == 0) {BTNC, BTNR, BTNL, BTND, BTNU} = 5'($urandom);
         screenEnd = ($urandom_range(0, 7) == 0);
         cyc();
      end
      screenEnd = 1'b0;
      {BTNU, BTND, BTNL, BTNR, BTNC} = '0;
      repeat (3) cyc();

      // reset mid-frame, off the clock edge
      #5 reset = 1'b0;
      probe("midreset_black", 190, 200, 1'b1, 12'h000, 0);
      repeat (2) cyc();
      reset = 1'b1;
      repeat (3) cyc();
      probe("rst_spr1", 190, 200, 1'b1, 12'hF00, 0);
      probe("rst_spr0_outline", 40, 200, 1'b1, 12'hFFF, 0);
      repeat (4) cyc();

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
